// File: rtl/riscv_isa.sv
// Shared ISA-level types for the backend: physical tag width and the result
// payload exchanged between execution units and writeback.
package riscv_isa;

  localparam int PTAG_W = 7;
  localparam int XLEN   = 32;

  typedef logic [PTAG_W-1:0] ptag_t;

  typedef struct packed {
    ptag_t             rd;
    logic [XLEN-1:0]   value;
    logic              we;
  } RESULT;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first requester
// found when searching upward from ptr, wrapping around.
module rr_arbiter #(
  parameter  int WIDTH = 4,
  localparam int PTR_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [WIDTH-1:0] grant
);

  int idx;

  // Scan from the farthest offset down so the nearest requester to ptr wins.
  always_comb begin
    grant = '0;
    idx   = 0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % WIDTH;
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Writeback arbiter: picks one execution-unit result per cycle, registers it
// as the register-file write, and maintains the per-tag ready bitmap.
module writeback_arbiter
  import riscv_isa::*;
#(
  parameter int UNITS = 4,
  parameter int PREGS = 128
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [UNITS-1:0]     result_valid,
  output logic [UNITS-1:0]     result_ready,
  input  RESULT                result_data [UNITS],
  input  logic                 alloc_valid,
  input  logic [PTAG_W-1:0]    alloc_addr,
  output logic                 write_en,
  output logic [PTAG_W-1:0]    write_addr,
  output logic [XLEN-1:0]      write_data,
  output logic [PREGS-1:0]     register_valid
);

  localparam int PTR_W = (UNITS > 1) ? $clog2(UNITS) : 1;

  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] ptr_next_p0;
  logic [UNITS-1:0] req_p0;
  logic [UNITS-1:0] grant_p0;
  RESULT            sel_p0;
  logic             vld_p0;
  logic             wr_p0;
  logic [PREGS-1:0] rv_next;

  // Stage p0: arbitration and payload select (combinational)
  assign req_p0 = reset ? '0 : result_valid;

  rr_arbiter #(.WIDTH(UNITS)) u_rr (
    .req   (req_p0),
    .ptr   (rr_ptr),
    .grant (grant_p0)
  );

  assign result_ready = grant_p0;

  always_comb begin
    sel_p0      = '0;
    ptr_next_p0 = rr_ptr;
    for (int i = 0; i < UNITS; i++) begin
      if (grant_p0[i]) begin
        sel_p0      = result_data[i];
        ptr_next_p0 = PTR_W'((i + 1) % UNITS);
      end
    end
  end

  assign vld_p0 = |grant_p0;
  assign wr_p0  = vld_p0 && sel_p0.we && (sel_p0.rd != '0);

  // Allocation clear is applied after the writeback set so it wins on a tie.
  always_comb begin
    rv_next = register_valid;
    if (wr_p0) begin
      rv_next[sel_p0.rd] = 1'b1;
    end
    if (alloc_valid && (alloc_addr != '0)) begin
      rv_next[alloc_addr] = 1'b0;
    end
    rv_next[0] = 1'b1;
  end

  // Stage p1: registered register-file write and ready bitmap
  always_ff @(posedge clk) begin
    if (reset) begin
      write_en       <= 1'b0;
      write_addr     <= '0;
      write_data     <= '0;
      rr_ptr         <= '0;
      register_valid <= '1;
    end else begin
      write_en       <= wr_p0;
      write_addr     <= sel_p0.rd;
      write_data     <= sel_p0.value;
      register_valid <= rv_next;
      if (vld_p0) begin
        rr_ptr <= ptr_next_p0;
      end
    end
  end

endmodule
